// File: rtl/single_cycle_cpu.sv
// Single-cycle MIPS subset core: add/sub/and/or/slt, addi, lw/sw, beq, j.
// Instruction and data memories are internal and preloaded hierarchically.

module cpu_pc (
  input  logic        clk,
  input  logic        rst,
  input  logic        en_i,
  input  logic [31:0] next_i,
  output logic [31:0] addr_o
);
  logic [31:0] pc_q, pc_d;

  always_comb begin
    pc_d = pc_q;
    if (en_i) pc_d = next_i;
  end

  always_ff @(posedge clk) begin
    if (rst) pc_q <= 32'd0;
    else     pc_q <= pc_d;
  end

  assign addr_o = pc_q;
endmodule

// Word-wide ROM; the write port exists only so the array has a driver and is tied off.
module cpu_instr_mem #(
  parameter int WORDS = 256,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [31:0]   wr_data_i,
  input  logic [AW-1:0] rd_addr_i,
  output logic [31:0]   rd_data_o
);
  logic [31:0] memory [0:WORDS-1];

  always_ff @(posedge clk) begin
    if (wr_en_i) memory[wr_addr_i] <= wr_data_i;
  end

  assign rd_data_o = memory[rd_addr_i];
endmodule

module cpu_data_mem #(
  parameter int BYTES = 32,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);
  logic [7:0] memory [0:BYTES-1];

  // Little-endian: byte k of the word lives at byte address {addr_i, k}.
  always_ff @(posedge clk) begin
    if (we_i) begin
      memory[{addr_i, 2'd0}] <= wdata_i[7:0];
      memory[{addr_i, 2'd1}] <= wdata_i[15:8];
      memory[{addr_i, 2'd2}] <= wdata_i[23:16];
      memory[{addr_i, 2'd3}] <= wdata_i[31:24];
    end
  end

  assign rdata_o = {memory[{addr_i, 2'd3}], memory[{addr_i, 2'd2}],
                    memory[{addr_i, 2'd1}], memory[{addr_i, 2'd0}]};
endmodule

module cpu_reg_file (
  input  logic        clk,
  input  logic        rst,
  input  logic        we_i,
  input  logic [4:0]  ra1_i,
  input  logic [4:0]  ra2_i,
  input  logic [4:0]  wa_i,
  input  logic [31:0] wd_i,
  output logic [31:0] rd1_o,
  output logic [31:0] rd2_o
);
  logic [31:0] register [0:31];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) register[i] <= 32'd0;
    end else if (we_i && (wa_i != 5'd0)) begin
      register[wa_i] <= wd_i;
    end
  end

  assign rd1_o = (ra1_i == 5'd0) ? 32'd0 : register[ra1_i];
  assign rd2_o = (ra2_i == 5'd0) ? 32'd0 : register[ra2_i];
endmodule

module single_cycle_cpu #(
  parameter int IMEM_WORDS = 256,
  parameter int DMEM_BYTES = 32
) (
  input logic clk,
  input logic rst,
  input logic start
);
  localparam int IMEM_AW = $clog2(IMEM_WORDS);
  localparam int DMEM_AW = $clog2(DMEM_BYTES / 4);

  logic [31:0] pc, pc_plus4, next_pc, instr, rs_val, rt_val, simm;
  logic [31:0] alu_res, mem_rdata, wr_data;
  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd, wr_addr;
  logic [15:0] imm;
  logic        reg_we, mem_we, run;
  logic [IMEM_AW-1:0] imem_idx;
  logic [DMEM_AW-1:0] dmem_idx;

  assign opcode   = instr[31:26];
  assign rs       = instr[25:21];
  assign rt       = instr[20:16];
  assign rd       = instr[15:11];
  assign imm      = instr[15:0];
  assign funct    = instr[5:0];
  assign simm     = {{16{imm[15]}}, imm};
  assign pc_plus4 = pc + 32'd4;
  assign run      = start & ~rst;
  assign imem_idx = IMEM_AW'(pc >> 2);
  assign dmem_idx = DMEM_AW'((rs_val + simm) >> 2);

  cpu_pc PC (
    .clk(clk), .rst(rst), .en_i(start), .next_i(next_pc), .addr_o(pc)
  );

  cpu_instr_mem #(.WORDS(IMEM_WORDS), .AW(IMEM_AW)) InstrMem (
    .clk(clk), .wr_en_i(1'b0), .wr_addr_i('0), .wr_data_i(32'd0),
    .rd_addr_i(imem_idx), .rd_data_o(instr)
  );

  cpu_reg_file RegFiles (
    .clk(clk), .rst(rst), .we_i(reg_we & run), .ra1_i(rs), .ra2_i(rt),
    .wa_i(wr_addr), .wd_i(wr_data), .rd1_o(rs_val), .rd2_o(rt_val)
  );

  cpu_data_mem #(.BYTES(DMEM_BYTES), .AW(DMEM_AW)) DataMem (
    .clk(clk), .we_i(mem_we & run), .addr_i(dmem_idx), .wdata_i(rt_val),
    .rdata_o(mem_rdata)
  );

  // Decode: anything not recognised falls through as a NOP advancing to PC+4.
  always_comb begin
    alu_res = 32'd0;
    reg_we  = 1'b0;
    mem_we  = 1'b0;
    wr_addr = rd;
    wr_data = 32'd0;
    next_pc = pc_plus4;
    case (opcode)
      6'h00: begin
        reg_we = 1'b1;
        case (funct)
          6'h20:   alu_res = rs_val + rt_val;
          6'h22:   alu_res = rs_val - rt_val;
          6'h24:   alu_res = rs_val & rt_val;
          6'h25:   alu_res = rs_val | rt_val;
          6'h2A:   alu_res = ($signed(rs_val) < $signed(rt_val)) ? 32'd1 : 32'd0;
          default: reg_we  = 1'b0;
        endcase
        wr_data = alu_res;
      end
      6'h08: begin
        reg_we  = 1'b1;
        wr_addr = rt;
        wr_data = rs_val + simm;
      end
      6'h23: begin
        reg_we  = 1'b1;
        wr_addr = rt;
        wr_data = mem_rdata;
      end
      6'h2B: mem_we = 1'b1;
      6'h04: if (rs_val == rt_val) next_pc = pc_plus4 + {simm[29:0], 2'b00};
      6'h02: next_pc = {pc_plus4[31:28], instr[25:0], 2'b00};
      default: ;
    endcase
  end
endmodule

// File: tb/tb_single_cycle_cpu.sv
// Bench for single_cycle_cpu: directed programs plus random programs checked
// against an instruction-level model of the CPU kept here.

module tb_single_cycle_cpu;
  localparam int IMEM = 256;
  localparam int DMEM = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;

  int checks = 0;
  int failures = 0;

  logic [31:0] m_imem [0:IMEM-1];
  logic [31:0] m_regs [0:31];
  logic [7:0]  m_dmem [0:DMEM-1];
  logic [31:0] m_pc = 32'd0;

  single_cycle_cpu #(.IMEM_WORDS(IMEM), .DMEM_BYTES(DMEM)) dut (
    .clk(clk), .rst(rst), .start(start)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] jtype(input logic [25:0] target);
    return {6'h02, target};
  endfunction

  function automatic logic [31:0] dutWord(input int w);
    return {dut.DataMem.memory[4*w+3], dut.DataMem.memory[4*w+2],
            dut.DataMem.memory[4*w+1], dut.DataMem.memory[4*w]};
  endfunction

  task automatic writeInstr(input int idx, input logic [31:0] word);
    dut.InstrMem.memory[idx] <= word;
    m_imem[idx] = word;
  endtask

  task automatic clearImem();
    for (int i = 0; i < IMEM; i++) writeInstr(i, 32'd0);
  endtask

  task automatic writeByte(input int idx, input logic [7:0] b);
    dut.DataMem.memory[idx] <= b;
    m_dmem[idx] = b;
  endtask

  task automatic modelWrite(input logic [4:0] d, input logic [31:0] v);
    if (d != 5'd0) m_regs[d] = v;
  endtask

  // Architectural step: what one clock edge does to PC, registers and memory.
  task automatic modelStep(input logic r, input logic s);
    logic [31:0] ins, a, b, sext, addr, npc;
    int w;
    if (r) begin
      m_pc = 32'd0;
      for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    end else if (s) begin
      ins  = m_imem[(m_pc >> 2) % IMEM];
      a    = m_regs[ins[25:21]];
      b    = m_regs[ins[20:16]];
      sext = 32'($signed(ins[15:0]));
      addr = a + sext;
      w    = int'((addr >> 2) % (DMEM / 4));
      npc  = m_pc + 32'd4;
      case (ins[31:26])
        6'h00: case (ins[5:0])
          6'h20: modelWrite(ins[15:11], a + b);
          6'h22: modelWrite(ins[15:11], a - b);
          6'h24: modelWrite(ins[15:11], a & b);
          6'h25: modelWrite(ins[15:11], a | b);
          6'h2A: modelWrite(ins[15:11], ($signed(a) < $signed(b)) ? 32'd1 : 32'd0);
          default: ;
        endcase
        6'h08: modelWrite(ins[20:16], a + sext);
        6'h23: modelWrite(ins[20:16], {m_dmem[4*w+3], m_dmem[4*w+2], m_dmem[4*w+1], m_dmem[4*w]});
        6'h2B: begin
          m_dmem[4*w]   = b[7:0];
          m_dmem[4*w+1] = b[15:8];
          m_dmem[4*w+2] = b[23:16];
          m_dmem[4*w+3] = b[31:24];
        end
        6'h04: if (a == b) npc = npc + (sext << 2);
        6'h02: npc = {npc[31:28], ins[25:0], 2'b00};
        default: ;
      endcase
      m_pc = npc;
    end
  endtask

  task automatic applyStimulus(input logic r, input logic s);
    rst   = r;
    start = s;
    modelStep(r, s);
    @(posedge clk);
    #1;
  endtask

  task automatic checkAgainstModel();
    checkOutput("pc", dut.PC.addr_o, m_pc);
    for (int i = 0; i < 32; i++)
      checkOutput($sformatf("reg%0d", i), dut.RegFiles.register[i], m_regs[i]);
    for (int w = 0; w < DMEM / 4; w++)
      checkOutput($sformatf("dmem_w%0d", w), dutWord(w),
                  {m_dmem[4*w+3], m_dmem[4*w+2], m_dmem[4*w+1], m_dmem[4*w]});
  endtask

  function automatic logic [4:0] randReg();
    return ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(8, 15));
  endfunction

  function automatic logic [31:0] randInstr();
    logic [5:0] fns [6] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h26};
    case ($urandom_range(0, 10))
      0, 1, 2, 3, 4: return rtype(randReg(), randReg(), randReg(), fns[$urandom_range(0, 5)]);
      5:  return itype(6'h08, randReg(), randReg(), 16'($urandom));
      6:  return itype(6'h23, randReg(), randReg(), 16'($urandom_range(0, 40)));
      7:  return itype(6'h2B, randReg(), randReg(), 16'($urandom_range(0, 40)));
      8:  return itype(6'h04, randReg(), randReg(), 16'(int'($urandom_range(0, 16)) - 8));
      9:  return jtype(26'($urandom_range(0, 31)));
      default: return itype(6'h0D, randReg(), randReg(), 16'($urandom));
    endcase
  endfunction

  initial begin
    for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    clearImem();
    for (int i = 0; i < DMEM; i++) writeByte(i, 8'h00);

    // Reset, then idle with start low.
    applyStimulus(1'b1, 1'b0);
    checkOutput("reset_pc", dut.PC.addr_o, 32'd0);
    for (int i = 0; i < 32; i++)
      checkOutput($sformatf("reset_reg%0d", i), dut.RegFiles.register[i], 32'd0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 1'b0);
      checkOutput("idle_pc", dut.PC.addr_o, 32'd0);
    end

    // ALU program.
    writeInstr(0, itype(6'h08, 5'd0, 5'd8, 16'd5));
    writeInstr(1, itype(6'h08, 5'd0, 5'd9, 16'hFFFD));
    writeInstr(2, rtype(5'd8, 5'd9, 5'd10, 6'h20));
    writeInstr(3, rtype(5'd9, 5'd8, 5'd11, 6'h2A));
    applyStimulus(1'b1, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1);
    checkOutput("alu_r8", dut.RegFiles.register[8], 32'd5);
    checkOutput("alu_r9", dut.RegFiles.register[9], 32'hFFFF_FFFD);
    checkOutput("alu_r10", dut.RegFiles.register[10], 32'd2);
    checkOutput("alu_r11", dut.RegFiles.register[11], 32'd1);
    checkOutput("alu_pc", dut.PC.addr_o, 32'd16);

    // Freeze after two instructions, then reset mid-program.
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0);
    checkOutput("hold_pc", dut.PC.addr_o, 32'd8);
    checkOutput("hold_r8", dut.RegFiles.register[8], 32'd5);
    checkOutput("hold_r9", dut.RegFiles.register[9], 32'hFFFF_FFFD);
    checkOutput("hold_r10", dut.RegFiles.register[10], 32'd0);
    applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1);
    checkOutput("midrst_pc", dut.PC.addr_o, 32'd0);
    checkOutput("midrst_r8", dut.RegFiles.register[8], 32'd0);
    checkOutput("midrst_r10", dut.RegFiles.register[10], 32'd0);

    // Memory program; a reset lands on the sw and must suppress it.
    clearImem();
    writeByte(0, 8'h05); writeByte(1, 8'h00); writeByte(2, 8'h00); writeByte(3, 8'h00);
    for (int i = 4; i < 8; i++) writeByte(i, 8'hAA);
    writeInstr(0, itype(6'h23, 5'd0, 5'd8, 16'd0));
    writeInstr(1, itype(6'h2B, 5'd0, 5'd8, 16'd4));
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1);
    checkOutput("lw_r8", dut.RegFiles.register[8], 32'd5);
    applyStimulus(1'b1, 1'b1);
    checkOutput("swrst_word4", dutWord(1), 32'hAAAA_AAAA);
    checkOutput("swrst_pc", dut.PC.addr_o, 32'd0);
    applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1);
    checkOutput("mem_r8", dut.RegFiles.register[8], 32'd5);
    checkOutput("mem_word4", dutWord(1), 32'd5);
    checkOutput("mem_pc", dut.PC.addr_o, 32'd8);

    // Control flow: beq taken and j.
    clearImem();
    writeInstr(0, itype(6'h08, 5'd0, 5'd8, 16'd1));
    writeInstr(1, itype(6'h04, 5'd8, 5'd8, 16'd1));
    writeInstr(2, itype(6'h08, 5'd0, 5'd9, 16'd7));
    writeInstr(3, jtype(26'd0));
    applyStimulus(1'b1, 1'b0);
    begin
      logic [31:0] exp_pc [6] = '{32'd4, 32'd12, 32'd0, 32'd4, 32'd12, 32'd0};
      for (int i = 0; i < 6; i++) begin
        applyStimulus(1'b0, 1'b1);
        checkOutput($sformatf("flow_pc%0d", i), dut.PC.addr_o, exp_pc[i]);
      end
    end
    checkOutput("taken_r9", dut.RegFiles.register[9], 32'd0);
    checkOutput("taken_r8", dut.RegFiles.register[8], 32'd1);

    // beq not taken.
    writeInstr(1, itype(6'h04, 5'd8, 5'd0, 16'd1));
    applyStimulus(1'b1, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1);
    checkOutput("nottaken_r9", dut.RegFiles.register[9], 32'd7);
    checkOutput("nottaken_pc", dut.PC.addr_o, 32'd12);

    // Register zero stays zero.
    clearImem();
    writeInstr(0, itype(6'h08, 5'd0, 5'd0, 16'd9));
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1);
    checkOutput("r0_value", dut.RegFiles.register[0], 32'd0);
    checkOutput("r0_pc", dut.PC.addr_o, 32'd4);
    checkAgainstModel();

    // Random programs with random start gaps and occasional resets.
    clearImem();
    for (int i = 0; i < 32; i++) writeInstr(i, randInstr());
    for (int i = 0; i < DMEM; i++) writeByte(i, 8'($urandom));
    applyStimulus(1'b1, 1'b0);
    checkAgainstModel();
    for (int n = 0; n < 2000; n++) begin
      applyStimulus($urandom_range(0, 49) == 0, $urandom_range(0, 9) != 0);
      checkAgainstModel();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
